// File: rtl/arm_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arm_mem_pkg
//  Purpose  : Shared types for the memory-access / MEM-WB pipeline stage.
//  Revision : 1.0  initial release
// ============================================================================
package arm_mem_pkg;

    // Memory-stage sequencer states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // Control bits carried into the W stage
    typedef struct packed {
        logic valid;
        logic regwrite;
        logic memtoreg;
        logic pcsrc;
    } wb_ctrl_t;

    // A bubble clears every W-stage control bit
    localparam wb_ctrl_t c_WB_BUBBLE = '0;

    // An M-stage slot needs the data memory only when it is real and loads or stores
    function automatic logic is_memop(input logic valid, input logic memwrite,
                                      input logic memtoreg);
        return valid & (memwrite | memtoreg);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_timeout_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : mem_timeout_ctr
//  Purpose  : Counts cycles spent waiting on the data memory and flags the
//             last permitted cycle. Saturates instead of wrapping.
//  Revision : 1.0  initial release
// ============================================================================
module mem_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int               c_CW   = $clog2(TIMEOUT + 1);
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(TIMEOUT - 1);
    localparam logic [c_CW-1:0]  c_MAX  = c_CW'(TIMEOUT);

    logic [c_CW-1:0] r_count;

    // Clear on entry to the wait phase, then count up and hold at the ceiling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != c_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // The cycle in which the counter reads TIMEOUT-1 is the last chance for an ack
    assign expired = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wb_stage
//  Purpose  : Memory-access stage with req/ack data-memory handshake, upstream
//             stall, access timeout, and the MEM/WB pipeline register.
//  Revision : 1.0  initial release
// ============================================================================
module mem_wb_stage #(
    parameter int DATA_W  = 32,
    parameter int RA_W    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ValidM,
    input  logic              MemWriteM,
    input  logic              MemToRegM,
    input  logic              RegWriteM,
    input  logic              PCSrcM,
    input  logic [DATA_W-1:0] ALUResultM,
    input  logic [DATA_W-1:0] WriteDataM,
    input  logic [RA_W-1:0]   WA3M,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              StallM,
    output logic              ValidW,
    output logic              RegWriteW,
    output logic              MemToRegW,
    output logic              PCSrcW,
    output logic [DATA_W-1:0] ALUOutW,
    output logic [DATA_W-1:0] ReadDataW,
    output logic [RA_W-1:0]   WA3W,
    output logic              bus_err
);

    import arm_mem_pkg::*;

    mem_state_t        r_state;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    wb_ctrl_t          r_ctrl;
    logic [RA_W-1:0]   r_ra;
    wb_ctrl_t          r_wb;
    logic [DATA_W-1:0] r_aluout;
    logic [DATA_W-1:0] r_rdata;
    logic [RA_W-1:0]   r_wa3;
    logic              r_bus_err;

    logic w_memop;
    logic w_idle;
    logic w_in_wait;
    logic w_start;
    logic w_done;
    logic w_timeout;
    logic w_expired;

    assign w_memop   = is_memop(ValidM, MemWriteM, MemToRegM);
    assign w_idle    = (r_state == IDLE);
    assign w_in_wait = (r_state == WAIT);
    assign w_start   = w_idle & w_memop;
    // An ack arriving on the expiry cycle still completes the access
    assign w_done    = w_in_wait & mem_ack;
    assign w_timeout = w_in_wait & ~mem_ack & w_expired;

    assign StallM    = w_start | (w_in_wait & ~mem_ack & ~w_expired);
    assign mem_req   = w_in_wait;
    assign mem_we    = w_in_wait & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_start),
        .enable  (w_in_wait),
        .expired (w_expired)
    );

    // Sequencer: leave IDLE on a memory op, return on ack or timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else if (w_start) begin
            r_state <= WAIT;
        end else if (w_done || w_timeout) begin
            r_state <= IDLE;
        end
    end

    // Capture the M-stage operation once; upstream is frozen while we wait
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_ctrl  <= c_WB_BUBBLE;
            r_ra    <= '0;
        end else if (w_start) begin
            r_addr  <= ALUResultM;
            r_wdata <= WriteDataM;
            r_we    <= MemWriteM;
            r_ctrl  <= '{valid: 1'b1, regwrite: RegWriteM, memtoreg: MemToRegM, pcsrc: PCSrcM};
            r_ra    <= WA3M;
        end
    end

    // Timeout flag is sticky until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus_err <= 1'b0;
        end else if (w_timeout) begin
            r_bus_err <= 1'b1;
        end
    end

    // MEM/WB register: retire a completed access, pass a non-memory op, else bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb     <= c_WB_BUBBLE;
            r_aluout <= '0;
            r_rdata  <= '0;
            r_wa3    <= '0;
        end else if (w_done) begin
            r_wb     <= r_ctrl;
            r_aluout <= r_addr;
            r_wa3    <= r_ra;
            if (r_ctrl.memtoreg) begin
                r_rdata <= mem_rdata;
            end
        end else if (w_idle && !w_memop) begin
            r_wb     <= '{valid: ValidM, regwrite: RegWriteM, memtoreg: MemToRegM, pcsrc: PCSrcM};
            r_aluout <= ALUResultM;
            r_wa3    <= WA3M;
        end else begin
            r_wb     <= c_WB_BUBBLE;
        end
    end

    assign ValidW    = r_wb.valid;
    assign RegWriteW = r_wb.regwrite;
    assign MemToRegW = r_wb.memtoreg;
    assign PCSrcW    = r_wb.pcsrc;
    assign ALUOutW   = r_aluout;
    assign ReadDataW = r_rdata;
    assign WA3W      = r_wa3;
    assign bus_err   = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_wb_stage
//  Purpose  : Self-checking bench for mem_wb_stage with a W-stage scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_wb_stage;

    localparam int DATA_W  = 32;
    localparam int RA_W    = 4;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ValidM, MemWriteM, MemToRegM, RegWriteM, PCSrcM;
    logic [DATA_W-1:0] ALUResultM, WriteDataM;
    logic [RA_W-1:0]   WA3M;
    logic              mem_req, mem_we, mem_ack;
    logic [DATA_W-1:0] mem_addr, mem_wdata, mem_rdata;
    logic              StallM, ValidW, RegWriteW, MemToRegW, PCSrcW, bus_err;
    logic [DATA_W-1:0] ALUOutW, ReadDataW;
    logic [RA_W-1:0]   WA3W;

    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] rd;
        logic [RA_W-1:0]   wa;
        logic              rw;
        logic              m2r;
        logic              pcs;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    bit   mon_on = 1'b0;

    always #5 clk = ~clk;

    mem_wb_stage #(
        .DATA_W  (DATA_W),
        .RA_W    (RA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ValidM     (ValidM),
        .MemWriteM  (MemWriteM),
        .MemToRegM  (MemToRegM),
        .RegWriteM  (RegWriteM),
        .PCSrcM     (PCSrcM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .WA3M       (WA3M),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .StallM     (StallM),
        .ValidW     (ValidW),
        .RegWriteW  (RegWriteW),
        .MemToRegW  (MemToRegW),
        .PCSrcW     (PCSrcW),
        .ALUOutW    (ALUOutW),
        .ReadDataW  (ReadDataW),
        .WA3W       (WA3W),
        .bus_err    (bus_err)
    );

    // Scoreboard: every retirement must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (mon_on && rst_n && ValidW === 1'b1) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL wb_unexpected: ValidW=1 WA3W=%0d ALUOutW=%h, required no retirement",
                         WA3W, ALUOutW);
            end else begin
                mon_e = q.pop_front();
                if ({ALUOutW, WA3W, RegWriteW, MemToRegW, PCSrcW} !==
                    {mon_e.alu, mon_e.wa, mon_e.rw, mon_e.m2r, mon_e.pcs}) begin
                    bad++;
                    $display("FAIL wb_ctrl: got alu=%h wa=%0d rw=%b m2r=%b pcs=%b, required alu=%h wa=%0d rw=%b m2r=%b pcs=%b",
                             ALUOutW, WA3W, RegWriteW, MemToRegW, PCSrcW,
                             mon_e.alu, mon_e.wa, mon_e.rw, mon_e.m2r, mon_e.pcs);
                end
                if (mon_e.m2r) begin
                    total++;
                    if (ReadDataW !== mon_e.rd) begin
                        bad++;
                        $display("FAIL wb_rdata: got %h, required %h", ReadDataW, mon_e.rd);
                    end
                end
            end
        end
    end

    task automatic clear_inputs();
        ValidM = 1'b0; MemWriteM = 1'b0; MemToRegM = 1'b0; RegWriteM = 1'b0; PCSrcM = 1'b0;
        ALUResultM = '0; WriteDataM = '0; WA3M = '0;
    endtask

    task automatic idle_cycles(input int n);
        clear_inputs();
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, StallM, ValidW, RegWriteW, MemToRegW,
             PCSrcW, ALUOutW, ReadDataW, WA3W, bus_err} !== '0) begin
            bad++;
            $display("FAIL reset_state: req=%b we=%b addr=%h wdata=%h stall=%b vw=%b alu=%h rd=%h wa=%0d err=%b, required all 0",
                     mem_req, mem_we, mem_addr, mem_wdata, StallM, ValidW, ALUOutW, ReadDataW, WA3W, bus_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mon_on = 1'b1;
        @(posedge clk); #1;
    endtask

    // One non-memory op; StallM must stay low and W updates after one edge
    task automatic test_alu_op(input logic [DATA_W-1:0] alu, input logic [RA_W-1:0] wa,
                               input logic rw, input logic pcs);
        ValidM = 1'b1; MemWriteM = 1'b0; MemToRegM = 1'b0; RegWriteM = rw; PCSrcM = pcs;
        ALUResultM = alu; WriteDataM = 32'h5555_0000; WA3M = wa;
        q.push_back('{alu: alu, rd: '0, wa: wa, rw: rw, m2r: 1'b0, pcs: pcs});
        @(negedge clk);
        total++;
        if (StallM !== 1'b0) begin
            bad++;
            $display("FAIL alu_stall: StallM=%b, required 0", StallM);
        end
        @(posedge clk); #1;
    endtask

    // One memory op; ack_at = WAIT cycle (1-based) carrying mem_ack, 0 = never
    task automatic test_memop(input bit is_load, input logic [DATA_W-1:0] addr,
                              input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] rdata,
                              input logic [RA_W-1:0] wa, input int ack_at);
        int n_req = 0;
        int n_stall = 0;
        int last;
        bit bad_bus = 1'b0;
        bit bad_vw = 1'b0;
        ValidM = 1'b1; MemWriteM = ~is_load; MemToRegM = is_load; RegWriteM = is_load;
        PCSrcM = 1'b0; ALUResultM = addr; WriteDataM = wdata; WA3M = wa;
        if (ack_at > 0)
            q.push_back('{alu: addr, rd: rdata, wa: wa, rw: is_load, m2r: is_load, pcs: 1'b0});
        last = (ack_at > 0) ? ack_at : TIMEOUT;
        for (int c = 0; c <= last; c++) begin
            if (c > 0 && c == ack_at) begin
                mem_ack = 1'b1; mem_rdata = rdata;
            end
            @(negedge clk);
            if (StallM === 1'b1) n_stall++;
            if (mem_req === 1'b1) begin
                n_req++;
                if (mem_addr !== addr || mem_we !== ~is_load || (!is_load && mem_wdata !== wdata))
                    bad_bus = 1'b1;
            end
            if (c > 0 && ValidW !== 1'b0) bad_vw = 1'b1;
            @(posedge clk); #1;
            mem_ack = 1'b0; mem_rdata = 32'hBAD0_BAD0;
        end
        total++;
        if (n_req != last) begin
            bad++;
            $display("FAIL memop_req_cycles: got %0d, required %0d (addr %h)", n_req, last, addr);
        end
        total++;
        if (n_stall != last) begin
            bad++;
            $display("FAIL memop_stall_cycles: got %0d, required %0d (addr %h)", n_stall, last, addr);
        end
        total++;
        if (bad_bus) begin
            bad++;
            $display("FAIL memop_bus: addr/we/wdata wrong during request, required addr=%h we=%b wdata=%h",
                     addr, ~is_load, wdata);
        end
        total++;
        if (bad_vw) begin
            bad++;
            $display("FAIL memop_validw: ValidW=1 while stalled, required 0 (addr %h)", addr);
        end
    endtask

    task automatic test_load();
        test_memop(1'b1, 32'h40, 32'h0, 32'hDEAD_BEEF, 4'd7, 4);  // ack on the expiry cycle
        test_memop(1'b1, 32'h44, 32'h0, 32'h0BAD_F00D, 4'd8, 2);
        idle_cycles(2);
        total++;
        if (bus_err !== 1'b0) begin
            bad++;
            $display("FAIL load_ack_wins: bus_err=%b, required 0", bus_err);
        end
    endtask

    task automatic test_store();
        test_memop(1'b0, 32'h80, 32'h0000_A5A5, 32'h0, 4'd3, 1);
        idle_cycles(2);
        total++;
        if (ReadDataW !== 32'h0BAD_F00D) begin
            bad++;
            $display("FAIL store_rdata_hold: ReadDataW=%h, required %h", ReadDataW, 32'h0BAD_F00D);
        end
    endtask

    task automatic test_timeout();
        test_memop(1'b1, 32'hC0, 32'h0, 32'h0, 4'd9, 0);
        idle_cycles(2);
        total++;
        if (bus_err !== 1'b1) begin
            bad++;
            $display("FAIL timeout_err: bus_err=%b, required 1", bus_err);
        end
        test_alu_op(32'h0000_7777, 4'd2, 1'b1, 1'b1);
        idle_cycles(3);
        total++;
        if (bus_err !== 1'b1) begin
            bad++;
            $display("FAIL timeout_sticky: bus_err=%b, required 1", bus_err);
        end
    endtask

    task automatic test_async_reset();
        ValidM = 1'b1; MemWriteM = 1'b0; MemToRegM = 1'b1; RegWriteM = 1'b1; PCSrcM = 1'b1;
        ALUResultM = 32'h1C0; WriteDataM = 32'h0; WA3M = 4'd11;
        repeat (2) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (mem_req !== 1'b0 || bus_err !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_req: mem_req=%b bus_err=%b, required 0 0", mem_req, bus_err);
        end
        total++;
        if ({mem_we, mem_addr, mem_wdata, ValidW, RegWriteW, MemToRegW, PCSrcW,
             ALUOutW, ReadDataW, WA3W} !== '0) begin
            bad++;
            $display("FAIL async_reset_outs: addr=%h vw=%b alu=%h rd=%h wa=%0d, required all 0",
                     mem_addr, ValidW, ALUOutW, ReadDataW, WA3W);
        end
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        total++;
        if (mem_req !== 1'b0 || StallM !== 1'b0) begin
            bad++;
            $display("FAIL spurious_ack_fsm: mem_req=%b StallM=%b, required 0 0", mem_req, StallM);
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        total++;
        if (ValidW !== 1'b0 || ReadDataW !== 32'h0) begin
            bad++;
            $display("FAIL spurious_ack_wb: ValidW=%b ReadDataW=%h, required 0 0", ValidW, ReadDataW);
        end
        @(posedge clk); #1;
        test_alu_op(32'h0000_ABCD, 4'd4, 1'b1, 1'b0);
        idle_cycles(2);
    endtask

    task automatic test_back_to_back();
        test_memop(1'b1, 32'h100, 32'h0, 32'h1111_1111, 4'd1, 1);
        test_memop(1'b1, 32'h104, 32'h0, 32'h2222_2222, 4'd2, 1);
        test_alu_op(32'h0000_0010, 4'd6, 1'b1, 1'b0);
        idle_cycles(3);
    endtask

    initial begin
        test_reset();
        test_alu_op(32'h0000_1234, 4'd5, 1'b1, 1'b0);
        test_alu_op(32'hFFFF_0001, 4'd15, 1'b0, 1'b1);
        idle_cycles(2);
        test_load();
        test_store();
        test_timeout();
        test_async_reset();
        test_back_to_back();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d retirements missing, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
